// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_if
// Brief    : Single-port data bus between the memory stage (master) and the
//            data memory / interconnect (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_wstrb;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;

  modport master (
    output d_req, d_we, d_addr, d_wstrb, d_wdata,
    input  d_ready, d_rdata
  );

  modport slave (
    input  d_req, d_we, d_addr, d_wstrb, d_wdata,
    output d_ready, d_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : Load/store stage: one transaction per access on a single-port
//            data bus, byte-lane steering, load sign/zero extension, stall.
//            Macro MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of
//            being forced to natural alignment.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  wire         clk,
  input  wire         rst_n,
  input  wire         flush,
  input  wire         regWriteEnable_in,
  input  wire  [31:0] instruction_in,
  input  wire  [31:0] PC_in,
  input  wire  [31:0] execute_rst_in,
  input  wire  [31:0] regData2_in,
  input  wire  [2:0]  memType_in,
  input  wire         memRead_in,
  input  wire         memWrite_in,
  output logic        stall_mem,
  output logic        regWriteEnable_out,
  output logic [31:0] instruction_out,
  output logic [31:0] PC_out,
  output logic [31:0] wb_data,
  output logic        mem_misaligned,
  output logic        mem_bus_err,
  mem_access_stage_if.master dbus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_tmo_last =
    (TIMEOUT_CYCLES == 0) ? '0 : c_cnt_w'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic               w_access;
  logic               w_accept;
  logic               w_illegal;
  logic               w_misalign;
  logic               w_decode_fault;
  logic               w_tmo_hit;
  logic               w_timeout;
  logic [3:0]         w_wstrb;
  logic [31:0]        w_wdata;

  logic               r_req;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [3:0]         r_wstrb;
  logic [31:0]        r_wdata;
  logic [2:0]         r_type;
  logic [1:0]         r_lo;
  logic               r_is_load;
  logic [31:0]        r_rdata;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_misaligned;
  logic               r_bus_err;

  logic [7:0]         w_lbyte;
  logic [15:0]        w_lhalf;
  logic [31:0]        w_load_ext;
  logic               w_fault;

  assign w_access       = memRead_in | memWrite_in;
  assign w_accept       = (r_state == ST_IDLE) && w_access && !flush;
  assign w_illegal      = (memType_in == 3'b011) || (memType_in[2:1] == 2'b11);
`ifdef MISALIGN_TRAP_EN
  assign w_misalign     = !w_illegal &&
                          (((memType_in[1:0] == 2'b01) && execute_rst_in[0]) ||
                           ((memType_in[1:0] == 2'b10) && (execute_rst_in[1:0] != 2'b00)));
`else
  assign w_misalign     = 1'b0;
`endif
  assign w_decode_fault = w_illegal | w_misalign;
  assign w_tmo_hit      = (TIMEOUT_CYCLES != 0) && (r_cnt == c_tmo_last);

  // Store lanes: ignoring the low address bits below the access size gives natural alignment
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    if (memWrite_in) begin
      case (memType_in[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << execute_rst_in[1:0];
          w_wdata = {4{regData2_in[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << {execute_rst_in[1], 1'b0};
          w_wdata = {2{regData2_in[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = regData2_in;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_mem   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          stall_mem   = 1'b1;
          w_state_nxt = w_decode_fault ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        stall_mem = 1'b1;
        if (dbus.d_ready) begin
          w_state_nxt = ST_DONE;
        end else if (w_tmo_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'h0;
      r_wstrb      <= 4'h0;
      r_wdata      <= 32'h0;
      r_type       <= 3'b000;
      r_lo         <= 2'b00;
      r_is_load    <= 1'b0;
      r_rdata      <= 32'h0;
      r_cnt        <= '0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_type       <= memType_in;
            r_lo         <= execute_rst_in[1:0];
            r_is_load    <= !memWrite_in;
            r_rdata      <= 32'h0;
            r_cnt        <= '0;
            r_bus_err    <= w_illegal;
            r_misaligned <= w_misalign;
            if (!w_decode_fault) begin
              r_req   <= 1'b1;
              r_we    <= memWrite_in;
              r_addr  <= {execute_rst_in[31:2], 2'b00};
              r_wstrb <= w_wstrb;
              r_wdata <= w_wdata;
            end
          end
        end
        ST_REQ: begin
          if (dbus.d_ready) r_rdata <= dbus.d_rdata;
          if (w_timeout)    r_bus_err <= 1'b1;
          if (w_state_nxt == ST_DONE) begin
            // Bus outputs read as zero whenever no request is outstanding
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wstrb <= 4'h0;
            r_wdata <= 32'h0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_bus_err    <= 1'b0;
          r_misaligned <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_lo)
      2'b00:   w_lbyte = r_rdata[7:0];
      2'b01:   w_lbyte = r_rdata[15:8];
      2'b10:   w_lbyte = r_rdata[23:16];
      default: w_lbyte = r_rdata[31:24];
    endcase
    w_lhalf = r_lo[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_type)
      3'b000:  w_load_ext = {{24{w_lbyte[7]}}, w_lbyte};
      3'b001:  w_load_ext = {{16{w_lhalf[15]}}, w_lhalf};
      3'b100:  w_load_ext = {24'h0, w_lbyte};
      3'b101:  w_load_ext = {16'h0, w_lhalf};
      default: w_load_ext = r_rdata;
    endcase
  end

  assign w_fault = (r_state == ST_DONE) && (r_bus_err || r_misaligned);

  always_comb begin
    wb_data = execute_rst_in;
    if (r_state == ST_DONE) begin
      if (w_fault)        wb_data = 32'h0;
      else if (r_is_load) wb_data = w_load_ext;
    end
  end

  assign regWriteEnable_out = regWriteEnable_in && !w_fault;
  assign instruction_out    = instruction_in;
  assign PC_out             = PC_in;
  assign mem_misaligned     = r_misaligned;
  assign mem_bus_err        = r_bus_err;

  assign dbus.d_req   = r_req;
  assign dbus.d_we    = r_we;
  assign dbus.d_addr  = r_addr;
  assign dbus.d_wstrb = r_wstrb;
  assign dbus.d_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Random pipeline/bus traffic against a transaction-level model of
//            mem_access_stage, plus directed scenarios with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        regWriteEnable_in = 1'b0;
  logic [31:0] instruction_in = 32'h0;
  logic [31:0] PC_in = 32'h0;
  logic [31:0] execute_rst_in = 32'h0;
  logic [31:0] regData2_in = 32'h0;
  logic [2:0]  memType_in = 3'b000;
  logic        memRead_in = 1'b0;
  logic        memWrite_in = 1'b0;
  logic        stall_mem, regWriteEnable_out, mem_misaligned, mem_bus_err;
  logic [31:0] instruction_out, PC_out, wb_data;

  mem_access_stage_if dbus();

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .regWriteEnable_in(regWriteEnable_in), .instruction_in(instruction_in),
    .PC_in(PC_in), .execute_rst_in(execute_rst_in), .regData2_in(regData2_in),
    .memType_in(memType_in), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
    .stall_mem(stall_mem), .regWriteEnable_out(regWriteEnable_out),
    .instruction_out(instruction_out), .PC_out(PC_out), .wb_data(wb_data),
    .mem_misaligned(mem_misaligned), .mem_bus_err(mem_bus_err),
    .dbus(dbus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall, req, we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata, wb;
    logic        rwe, mis, berr;
    logic [31:0] instr, pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * a[1:0])) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    case (t)
      3'd0:    return (b ^ 32'h80) - 32'h80;
      3'd1:    return (h ^ 32'h8000) - 32'h8000;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] t, input logic [31:0] a);
    case (t[1:0])
      2'b00:   return 4'(1 << a[1:0]);
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] d);
    case (t[1:0])
      2'b00:   return d[7:0] * 32'h01010101;
      2'b01:   return d[15:0] * 32'h00010001;
      default: return d;
    endcase
  endfunction

  // ---------------- single compare process ----------------
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cmp_e = exp_q.pop_front();
      chk("stall_mem", 32'(stall_mem), 32'(cmp_e.stall));
      chk("d_req", 32'(dbus.d_req), 32'(cmp_e.req));
      chk("d_we", 32'(dbus.d_we), 32'(cmp_e.we));
      chk("d_addr", dbus.d_addr, cmp_e.addr);
      chk("d_wstrb", 32'(dbus.d_wstrb), 32'(cmp_e.wstrb));
      chk("d_wdata", dbus.d_wdata, cmp_e.wdata);
      chk("wb_data", wb_data, cmp_e.wb);
      chk("regWriteEnable_out", 32'(regWriteEnable_out), 32'(cmp_e.rwe));
      chk("mem_misaligned", 32'(mem_misaligned), 32'(cmp_e.mis));
      chk("mem_bus_err", 32'(mem_bus_err), 32'(cmp_e.berr));
      chk("instruction_out", instruction_out, cmp_e.instr);
      chk("PC_out", PC_out, cmp_e.pc);
    end
  end

  // ---------------- monitor for directed literal checks ----------------
  int          mon_stall, mon_req, mon_we;
  logic [31:0] mon_addr, mon_wdata, last_wb;
  logic [3:0]  mon_wstrb;
  logic        last_rwe, last_berr, last_mis;

  always @(negedge clk) begin
    if (stall_mem) mon_stall++;
    if (dbus.d_req) begin
      mon_req++;
      mon_addr  = dbus.d_addr;
      mon_wstrb = dbus.d_wstrb;
      mon_wdata = dbus.d_wdata;
    end
    if (dbus.d_we) mon_we++;
    last_wb   = wb_data;
    last_rwe  = regWriteEnable_out;
    last_berr = mem_bus_err;
    last_mis  = mem_misaligned;
  end

  // One EX/MEM entry held until its access completes; the slave answers after
  // 'waits' wait states, or never when noready is set.
  task automatic run_instr(input logic rd, input logic wr, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] d, input logic rwe,
                           input logic fl, input int waits, input bit noready,
                           input logic [31:0] rdv);
    exp_t e;
    logic access, illegal, mis, fault, tmo, is_load;
    logic [31:0] ins, pc;
    int nreq;
    ins = $urandom;
    pc  = $urandom;
    access  = (rd || wr) && !fl;
    illegal = (t == 3'd3) || (t == 3'd6) || (t == 3'd7);
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = !illegal && (((t[1:0] == 2'b01) && a[0]) || ((t[1:0] == 2'b10) && (a[1:0] != 2'b00)));
`endif
    fault   = illegal || mis;
    is_load = rd && !wr;
    tmo     = access && !fault && noready;
    nreq    = (!access || fault) ? 0 : (noready ? int'(TMO) : waits + 1);
    mon_stall = 0; mon_req = 0; mon_we = 0;
    mon_addr = 32'h0; mon_wstrb = 4'h0; mon_wdata = 32'h0;

    @(posedge clk); #1;
    memRead_in = rd; memWrite_in = wr; memType_in = t; execute_rst_in = a;
    regData2_in = d; regWriteEnable_in = rwe; flush = fl;
    instruction_in = ins; PC_in = pc;
    dbus.d_ready = 1'b0; dbus.d_rdata = $urandom;
    e = '0;
    e.stall = access; e.wb = a; e.rwe = rwe; e.instr = ins; e.pc = pc;
    exp_q.push_back(e);

    if (access) begin
      for (int i = 1; i <= nreq; i++) begin
        @(posedge clk); #1;
        flush = 1'($urandom_range(0, 1));
        dbus.d_ready = !noready && (i == nreq);
        dbus.d_rdata = dbus.d_ready ? rdv : $urandom;
        e.stall = 1'b1; e.req = 1'b1; e.we = wr;
        e.addr  = a & 32'hFFFF_FFFC;
        e.wstrb = wr ? m_wstrb(t, a) : 4'h0;
        e.wdata = wr ? m_wdata(t, d) : 32'h0;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
      flush = 1'($urandom_range(0, 1));
      dbus.d_ready = 1'b0; dbus.d_rdata = $urandom;
      e = '0;
      e.instr = ins; e.pc = pc;
      e.mis  = mis;
      e.berr = illegal || tmo;
      e.wb   = (fault || tmo) ? 32'h0 : (is_load ? m_load(t, a, rdv) : a);
      e.rwe  = (fault || tmo) ? 1'b0 : rwe;
      exp_q.push_back(e);
    end
    @(negedge clk); #1;
  endtask

  task automatic zero_inputs();
    memRead_in = 0; memWrite_in = 0; memType_in = 0; execute_rst_in = 0;
    regData2_in = 0; regWriteEnable_in = 0; flush = 0; instruction_in = 0; PC_in = 0;
    dbus.d_ready = 0; dbus.d_rdata = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_mem), 32'h0);
    chk({tag, "_rwe"}, 32'(regWriteEnable_out), 32'h0);
    chk({tag, "_instr"}, instruction_out, 32'h0);
    chk({tag, "_pc"}, PC_out, 32'h0);
    chk({tag, "_wb"}, wb_data, 32'h0);
    chk({tag, "_mis"}, 32'(mem_misaligned), 32'h0);
    chk({tag, "_berr"}, 32'(mem_bus_err), 32'h0);
    chk({tag, "_req"}, 32'(dbus.d_req), 32'h0);
    chk({tag, "_we"}, 32'(dbus.d_we), 32'h0);
    chk({tag, "_addr"}, dbus.d_addr, 32'h0);
    chk({tag, "_wstrb"}, 32'(dbus.d_wstrb), 32'h0);
    chk({tag, "_wdata"}, dbus.d_wdata, 32'h0);
  endtask

  logic [2:0] legal_t [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    int sel;
    logic [2:0] t;
    zero_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1;

    // Pin the model against hand-computed values
    chk("model_lb", m_load(3'd0, 32'h103, 32'h80AB_CDEF), 32'hFFFF_FF80);
    chk("model_lhu", m_load(3'd5, 32'h002, 32'h80AB_CDEF), 32'h0000_80AB);
    chk("model_sh_wstrb", 32'(m_wstrb(3'd1, 32'h202)), 32'h0000_000C);
    chk("model_sh_wdata", m_wdata(3'd1, 32'h0000_BEEF), 32'hBEEF_BEEF);

    // 1: no access
    run_instr(0, 0, 3'd0, 32'h0000_1234, 32'h0, 1, 0, 0, 0, 32'h0);
    chk("t1_stall_cycles", 32'(mon_stall), 32'd0);
    chk("t1_wb", last_wb, 32'h0000_1234);

    // 2: LB 0x103, zero wait
    run_instr(1, 0, 3'd0, 32'h103, 32'h0, 1, 0, 0, 0, 32'h80AB_CDEF);
    chk("t2_stall_cycles", 32'(mon_stall), 32'd2);
    chk("t2_req_cycles", 32'(mon_req), 32'd1);
    chk("t2_addr", mon_addr, 32'h100);
    chk("t2_wb", last_wb, 32'hFFFF_FF80);

    // 3: SH 0x202, three wait states
    run_instr(0, 1, 3'd1, 32'h202, 32'h0000_BEEF, 1, 0, 3, 0, 32'h0);
    chk("t3_req_cycles", 32'(mon_req), 32'd4);
    chk("t3_we_cycles", 32'(mon_we), 32'd4);
    chk("t3_wstrb", 32'(mon_wstrb), 32'h0000_000C);
    chk("t3_wdata", mon_wdata, 32'hBEEF_BEEF);
    chk("t3_rwe", 32'(last_rwe), 32'd1);

    // 4: LW, bus never ready
    run_instr(1, 0, 3'd2, 32'h0000_0500, 32'h0, 1, 0, 0, 1, 32'h0);
    chk("t4_req_cycles", 32'(mon_req), 32'd16);
    chk("t4_berr", 32'(last_berr), 32'd1);
    chk("t4_wb", last_wb, 32'h0);
    chk("t4_rwe", 32'(last_rwe), 32'd0);

    // 5: LW 0x301
    run_instr(1, 0, 3'd2, 32'h301, 32'h0, 1, 0, 0, 0, 32'h1234_5678);
`ifdef MISALIGN_TRAP_EN
    chk("t5_req_cycles", 32'(mon_req), 32'd0);
    chk("t5_mis", 32'(last_mis), 32'd1);
    chk("t5_rwe", 32'(last_rwe), 32'd0);
`else
    chk("t5_req_cycles", 32'(mon_req), 32'd1);
    chk("t5_addr", mon_addr, 32'h300);
    chk("t5_wb", last_wb, 32'h1234_5678);
`endif

    // 6: reset while a request is outstanding
    @(posedge clk); #1;
    memRead_in = 1; memType_in = 3'd2; execute_rst_in = 32'h400; regWriteEnable_in = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_req_before_reset", 32'(dbus.d_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_req_async_drop", 32'(dbus.d_req), 32'd0);
    zero_inputs();
    #1;
    chk_all_zero("t6_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("t6_after_release");
    @(negedge clk); #1;

    // flushed load in IDLE
    run_instr(1, 0, 3'd2, 32'h700, 32'h0, 1, 1, 0, 0, 32'h0);
    chk("flush_stall_cycles", 32'(mon_stall), 32'd0);
    chk("flush_req_cycles", 32'(mon_req), 32'd0);
    chk("flush_wb", last_wb, 32'h700);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      t = ($urandom_range(0, 9) < 8) ? legal_t[$urandom_range(0, 4)] : 3'($urandom);
      run_instr(sel >= 3 && sel != 6 && sel != 7 && sel != 8 || sel == 9 ? 1'b1 : 1'b0,
                (sel >= 6) ? 1'b1 : 1'b0, t, $urandom, $urandom,
                1'($urandom), ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
                ($urandom_range(0, 39) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of the EX/MEM pipeline register.
- Consumes the execute result (address), store data, memType, memRead and memWrite.
- Runs one load/store transaction on a single-port data bus. Performs byte-lane steering and load sign/zero extension.
- Stalls the pipeline until the transaction completes, then presents write-back data to the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in REQ waiting for d_ready before a bus error is declared; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  squash the access offered this cycle (effective in IDLE only)
- regWriteEnable_in  input  1  from EX/MEM
- instruction_in  input  32  from EX/MEM
- PC_in  input  32  from EX/MEM
- execute_rst_in  input  32  ALU result: memory address, or write-back value for non-memory ops
- regData2_in  input  32  store data
- memType_in  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- memRead_in  input  1  load request
- memWrite_in  input  1  store request
- stall_mem  output  1  hold IF through EX/MEM
- regWriteEnable_out  output  1  to MEM/WB; masked to 0 on any fault
- instruction_out  output  32  pass-through
- PC_out  output  32  pass-through
- wb_data  output  32  load result, or execute_rst_in for non-memory ops
- mem_misaligned  output  1  misaligned-access fault (see Optional Feature)
- mem_bus_err  output  1  timeout or illegal memType fault
- d_req  output  1  bus request, registered
- d_we  output  1  1 = store
- d_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- d_wstrb  output  4  byte enables
- d_wdata  output  32  lane-replicated store data
- d_ready  input  1  transaction complete; d_rdata valid in the same cycle
- d_rdata  input  32  read data

Behaviour:
- Reset: every output is 0. FSM enters IDLE. Timeout counter is cleared. Reset mid-transaction drops d_req immediately.
- No access (memRead_in=memWrite_in=0):
  - wb_data=execute_rst_in, combinational, 0 latency.
  - stall_mem=0; pass-through outputs follow the inputs.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Access present and flush=0: stall_mem=1 combinationally. Latch address, data, type and direction. Next state is REQ, or DONE if a fault is detected at decode.
  - flush=1: the access is ignored; no stall.
- REQ:
  - d_req=1, stall_mem=1; d_we, d_addr, d_wstrb and d_wdata are held stable.
  - On d_ready: capture d_rdata, drop d_req, go to DONE.
  - Timeout counter increments each REQ cycle. On reaching TIMEOUT_CYCLES without d_ready: drop d_req, set the bus-error flag, go to DONE.
  - flush is ignored in REQ and DONE.
- DONE:
  - stall_mem=0; wb_data holds the extended load data, or 0 on fault.
  - mem_misaligned and mem_bus_err are valid for this cycle only.
  - Next state is IDLE. The pipeline advances on this edge, so the same access is never reissued.
- Minimum occupancy (zero-wait bus): 3 cycles, with stall_mem high for 2.
- Store steering:
  - SB: d_wstrb=4'b0001<<addr[1:0]; byte replicated ×4.
  - SH: d_wstrb=4'b0011<<{addr[1],1'b0}; halfword replicated ×2.
  - SW: d_wstrb=4'b1111.
- Loads: d_wstrb=0. Select the lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Illegal memType (011, 110, 111) with an access: no bus cycle; IDLE→DONE with mem_bus_err=1.
- memRead and memWrite both set: treated as a store.
- regWriteEnable_out=0 whenever either fault flag is set in DONE.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - H access with addr[0]=1, or W access with addr[1:0]≠0, is a fault.
  - No bus cycle; IDLE→DONE; mem_misaligned=1 in DONE; regWriteEnable_out=0; wb_data=0.
- Undefined:
  - Offending low address bits are forced to the natural alignment and the access proceeds normally.
  - mem_misaligned is tied to 0.

Test Plan:
1. No access, execute_rst_in=0x0000_1234 → wb_data=0x0000_1234 in the same cycle; stall_mem never asserted.
2. LB addr=0x103, d_rdata=0x80AB_CDEF, d_ready on the first REQ cycle → d_addr=0x100; d_req high 1 cycle; DONE wb_data=0xFFFF_FF80; stall_mem high exactly 2 cycles.
3. SH addr=0x202, regData2_in=0x0000_BEEF, 3 wait states → d_wstrb=4'b1100, d_wdata=0xBEEF_BEEF, d_we=1 stable for 4 REQ cycles; regWriteEnable_out passes through.
4. LW with d_ready never asserted, TIMEOUT_CYCLES=16 → d_req drops after 16 REQ cycles; DONE mem_bus_err=1, wb_data=0, regWriteEnable_out=0.
5. LW addr=0x301 → with MISALIGN_TRAP_EN: no d_req, mem_misaligned=1 one cycle after accept. Without it: d_addr=0x300, normal load.
6. rst_n low during REQ → d_req=0 asynchronously; after release the FSM is in IDLE and all outputs are 0. Flush asserted in IDLE with a load → no d_req and no stall.
